output_ram_ctrl: RTL
====================

// Module: output_ram_ctrl
//
// PURPOSE
// Sequencer and access arbiter for the output-unit RAM of the classifier.
// In IDLE it forwards output-neuron result writes from the compute engine into the RAM.
// On scan_start it reads entries 0..NUM_OUT-1 and tracks the running maximum.
// It then reports the winning index and value (the classification) with a done pulse.
//
// PARAMETERS
// DATA_WIDTH  8   width of one output-neuron score (unsigned)
// ADDR_WIDTH  4   RAM address width; RAM depth = 2**ADDR_WIDTH
// NUM_OUT     10  number of valid output entries scanned; NUM_OUT <= 2**ADDR_WIDTH
//
// PORTS
// clk        in   1           system clock, all state on posedge
// rst_n      in   1           synchronous reset, active low
// wr_req     in   1           compute engine requests a result write
// wr_addr    in   ADDR_WIDTH  result index
// wr_data    in   DATA_WIDTH  result score
// wr_gnt     out  1           write accepted this cycle (combinational)
// scan_start in   1           one-cycle pulse: begin max scan
// busy       out  1           scan in progress (SCAN or DRAIN)
// done       out  1           one-cycle pulse: max_idx/max_val valid
// max_idx    out  ADDR_WIDTH  index of the maximum score
// max_val    out  DATA_WIDTH  maximum score
// ram_we     out  1           RAM write enable
// ram_addr   out  ADDR_WIDTH  RAM address (RAM registers it at posedge)
// ram_data   out  DATA_WIDTH  RAM write data
// ram_q      in   DATA_WIDTH  RAM read data for the address registered last edge
//
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state IDLE, cnt 0, pending 0; busy/done/ram_we 0;
//   max_idx 0, max_val 0. RAM contents are not touched.
// - RAM read latency: address on ram_addr at edge t; data on ram_q during cycle t+1.
// - FSM states: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
// - IDLE:
//   - wr_gnt = wr_req; ram_addr = wr_addr; ram_data = wr_data.
//   - ram_we = wr_req & (wr_addr < NUM_OUT). Out-of-range writes are granted and dropped.
//   - scan_start, or pending=1, with no wr_req: go to SCAN, cnt=0.
//     Clear max_val and max_idx to 0, and clear pending.
//   - scan_start together with wr_req: the write wins; set pending=1.
//     The scan starts at the first IDLE cycle without wr_req.
// - SCAN:
//   - Lasts NUM_OUT cycles; ram_addr = cnt; cnt increments 0..NUM_OUT-1.
//   - ram_we = 0; wr_gnt = 0, so writes stall; scan_start is ignored.
//   - From the 2nd SCAN cycle, compare ram_q (entry cnt-1) against max_val.
// - DRAIN: one cycle; compare ram_q (entry NUM_OUT-1).
// - Compare rule: unsigned; update only if ram_q > max_val (strict).
//   Ties keep the lower index; all-zero scores give idx 0, val 0.
// - DONE: one cycle; done=1; wr_gnt=0; then return to IDLE.
// - Latency: scan_start accepted at edge k gives SCAN cycles k+1..k+NUM_OUT.
//   DRAIN is at cycle k+NUM_OUT+1; done=1 at cycle k+NUM_OUT+2.
// - busy = (state==SCAN) | (state==DRAIN).
// - max_idx/max_val hold after DONE until the next scan is accepted.
// - Reset mid-scan: abort immediately to the reset values above.
//   No done pulse; pending cleared.
//
// TESTING
// 1. Write scores {3,9,1,0,7,2,8,4,5,6} to 0..9, pulse scan_start.
//    -> done exactly 12 cycles later; max_idx=1, max_val=9.
// 2. Scores with a tie: 200 at idx 4 and idx 7, others 10.
//    -> max_idx=4, max_val=200.
// 3. Hold wr_req during SCAN.
//    -> wr_gnt=0 and ram_we=0 through SCAN/DRAIN/DONE.
//    -> the write is granted in the first IDLE cycle.
// 4. scan_start and wr_req(addr 2, data 255) in the same cycle.
//    -> the write lands first; the scan starts when wr_req drops.
//    -> max_idx=2, max_val=255.
// 5. Write to addr 12 (>= NUM_OUT).
//    -> wr_gnt=1 and ram_we=0; a later scan is unaffected.
// 6. Assert rst_n=0 at the 5th SCAN cycle.
//    -> next cycle busy=0, max_val=0, no done.
//    -> a new scan afterwards gives the correct result.

Source files
------------

// File: rtl/output_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : output_ram_ctrl
//  Description : Output-unit RAM sequencer for the classifier. Forwards
//                compute-engine result writes while idle, and on request
//                scans the valid entries for the maximum score and reports
//                the winning index and value with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_OUT    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  scan_start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] max_idx,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Last scanned index, and entry count widened by one bit so NUM_OUT may
  // equal the full RAM depth.
  localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(NUM_OUT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_NUM  = (ADDR_WIDTH + 1)'(NUM_OUT);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  r_pending, w_pend_nxt;
  logic [ADDR_WIDTH-1:0] r_max_idx, w_max_idx_nxt;
  logic [DATA_WIDTH-1:0] r_max_val, w_max_val_nxt;
  logic                  w_in_range;
  logic                  w_cmp_en;
  logic [ADDR_WIDTH-1:0] w_cmp_idx;

  assign w_in_range = ({1'b0, wr_addr} < c_NUM);

  // State and datapath registers; reset aborts any scan without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_max_idx <= '0;
      r_max_val <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pend_nxt;
      r_max_idx <= w_max_idx_nxt;
      r_max_val <= w_max_val_nxt;
    end
  end

  // Next-state, RAM port arbitration and running-maximum update.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pending;
    w_max_idx_nxt = r_max_idx;
    w_max_val_nxt = r_max_val;
    wr_gnt        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = wr_addr;
    ram_data      = wr_data;
    w_cmp_en      = 1'b0;
    w_cmp_idx     = r_cnt - c_ONE;   // ram_q lags the scan address by one cycle

    case (r_state)
      S_IDLE: begin
        wr_gnt = wr_req;
        // Out-of-range writes are acknowledged but never reach the RAM.
        ram_we = wr_req & w_in_range;
        if (wr_req) begin
          // A colliding write wins; remember the scan request for later.
          if (scan_start) w_pend_nxt = 1'b1;
        end else if (scan_start || r_pending) begin
          w_state_nxt   = S_SCAN;
          w_cnt_nxt     = '0;
          w_pend_nxt    = 1'b0;
          w_max_idx_nxt = '0;
          w_max_val_nxt = '0;
        end
      end
      S_SCAN: begin
        ram_addr = r_cnt;
        w_cmp_en = (r_cnt != '0);
        if (r_cnt == c_LAST) w_state_nxt = S_DRAIN;
        else                 w_cnt_nxt   = r_cnt + c_ONE;
      end
      S_DRAIN: begin
        w_cmp_en    = 1'b1;
        w_cmp_idx   = c_LAST;
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Strict compare so ties keep the lower index.
    if (w_cmp_en && (ram_q > r_max_val)) begin
      w_max_val_nxt = ram_q;
      w_max_idx_nxt = w_cmp_idx;
    end
  end

  assign busy    = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done    = (r_state == S_DONE);
  assign max_idx = r_max_idx;
  assign max_val = r_max_val;

endmodule
`default_nettype wire
